aes_dec_sched: RTL and testbench

AES_DEC_SCHED -- requirements
Module: aes_dec_sched

---
 rtl/aes_pkg.sv | 21 ++
 rtl/aes_dec_sched.sv | 166 ++++++++++++++++
 tb/tb_aes_dec_sched.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared constants for the AES-128 decryption scheduler: round count,
// key-expansion round constants and the scheduler state encoding.
package aes_pkg;

    localparam int NR = 10;

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEXP,
        S_ARK,
        S_ROUND,
        S_FINAL,
        S_DONE
    } aes_state_e;

endpackage

// File: rtl/aes_dec_sched.sv
// Control sequencer for an iterative AES-128 decryption datapath: forward key
// expansion to the last round key, then inverse rounds stepping the key back.
//   state | meaning
//   IDLE  | waiting for a key/ciphertext handshake
//   KEXP  | NR forward key-expansion steps
//   ARK   | initial AddRoundKey with the last round key
//   ROUND | NR-1 full inverse rounds
//   FINAL | last round, no InvMixColumns
//   DONE  | plaintext held until consumed
module aes_dec_sched
    import aes_pkg::*;
#(
    parameter int NR = aes_pkg::NR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       dp_load,
    output logic       ks_fwd_en,
    output logic       ks_inv_en,
    output logic       rnd_en,
    output logic       rnd_first,
    output logic       rnd_last,
    output logic [3:0] rnd_idx,
    output logic [7:0] rcon,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    aes_state_e r_state;
    logic [3:0] r_step;
    logic [3:0] r_rnd_idx;
    logic       r_in_ready;
    logic       r_busy;
    logic       r_out_valid;
    logic       r_ks_fwd_en;
    logic       r_ks_inv_en;
    logic       r_rnd_en;
    logic       r_rnd_first;
    logic       r_rnd_last;
    logic [7:0] r_rcon;
    logic [3:0] w_rcon_sel;

    // Key used in the next ROUND cycle is two below the current index.
    assign w_rcon_sel = r_rnd_idx - 4'd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_step      <= '0;
            r_rnd_idx   <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_ks_fwd_en <= 1'b0;
            r_ks_inv_en <= 1'b0;
            r_rnd_en    <= 1'b0;
            r_rnd_first <= 1'b0;
            r_rnd_last  <= 1'b0;
            r_rcon      <= 8'h00;
        end else begin
            r_step      <= '0;
            r_rnd_idx   <= '0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_out_valid <= 1'b0;
            r_ks_fwd_en <= 1'b0;
            r_ks_inv_en <= 1'b0;
            r_rnd_en    <= 1'b0;
            r_rnd_first <= 1'b0;
            r_rnd_last  <= 1'b0;
            r_rcon      <= 8'h00;

            if (flush && (r_state != S_IDLE)) begin
                r_state    <= S_IDLE;
                r_in_ready <= 1'b1;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (in_valid) begin
                            r_state     <= S_KEXP;
                            r_step      <= 4'd1;
                            r_ks_fwd_en <= 1'b1;
                            r_rcon      <= RCON[0];
                        end else begin
                            r_state    <= S_IDLE;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b0;
                        end
                    end
                    S_KEXP: begin
                        if (r_step >= 4'(NR)) begin
                            r_state     <= S_ARK;
                            r_rnd_idx   <= 4'(NR);
                            r_rnd_en    <= 1'b1;
                            r_rnd_first <= 1'b1;
                            r_ks_inv_en <= 1'b1;
                            r_rcon      <= RCON[NR-1];
                        end else begin
                            r_state     <= S_KEXP;
                            r_step      <= r_step + 4'd1;
                            r_ks_fwd_en <= 1'b1;
                            r_rcon      <= RCON[r_step];
                        end
                    end
                    S_ARK: begin
                        r_state     <= S_ROUND;
                        r_rnd_idx   <= 4'(NR - 1);
                        r_rnd_en    <= 1'b1;
                        r_ks_inv_en <= 1'b1;
                        r_rcon      <= RCON[NR-2];
                    end
                    S_ROUND: begin
                        if (r_rnd_idx <= 4'd1) begin
                            r_state    <= S_FINAL;
                            r_rnd_en   <= 1'b1;
                            r_rnd_last <= 1'b1;
                        end else begin
                            r_state     <= S_ROUND;
                            r_rnd_idx   <= r_rnd_idx - 4'd1;
                            r_rnd_en    <= 1'b1;
                            r_ks_inv_en <= 1'b1;
                            r_rcon      <= RCON[w_rcon_sel];
                        end
                    end
                    S_FINAL: begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end
                    S_DONE: begin
                        if (out_ready) begin
                            r_state    <= S_IDLE;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b0;
                        end else begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                        end
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign dp_load   = in_valid & r_in_ready;
    assign ks_fwd_en = r_ks_fwd_en;
    assign ks_inv_en = r_ks_inv_en;
    assign rnd_en    = r_rnd_en;
    assign rnd_first = r_rnd_first;
    assign rnd_last  = r_rnd_last;
    assign rnd_idx   = r_rnd_idx;
    assign rcon      = r_rcon;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_aes_dec_sched.sv
// Self-checking bench for aes_dec_sched: per-cycle expected control words come
// from a table built from the round schedule, queued as stimulus is applied.
module tb_aes_dec_sched;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       dp_load;
    logic       ks_fwd_en;
    logic       ks_inv_en;
    logic       rnd_en;
    logic       rnd_first;
    logic       rnd_last;
    logic [3:0] rnd_idx;
    logic [7:0] rcon;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    aes_dec_sched #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dp_load   (dp_load),
        .ks_fwd_en (ks_fwd_en),
        .ks_inv_en (ks_inv_en),
        .rnd_en    (rnd_en),
        .rnd_first (rnd_first),
        .rnd_last  (rnd_last),
        .rnd_idx   (rnd_idx),
        .rcon      (rcon),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [19:0] e;
    } vec_t;

    logic [7:0]  rcon_tb [10];
    vec_t        vec [23];
    logic [19:0] idle_r;
    logic [19:0] exp_q [$];
    int          n_chk;
    int          n_fail;
    int          cyc;
    int          load_cyc [$];
    // Datapath operands for the scenarios; the scheduler only sequences them.
    logic [127:0] key_tab [3];
    logic [127:0] ct_word;

    logic [19:0] w_act;
    assign w_act = {in_ready, busy, ks_fwd_en, ks_inv_en, rnd_en,
                    rnd_first, rnd_last, out_valid, rnd_idx, rcon};

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (dp_load) load_cyc.push_back(cyc);

    function automatic logic [19:0] rec(bit ir, bit bz, bit fw, bit iv, bit en,
                                        bit fi, bit la, bit ov,
                                        logic [3:0] idx, logic [7:0] rc);
        return {ir, bz, fw, iv, en, fi, la, ov, idx, rc};
    endfunction

    task automatic check(string nm, logic [19:0] a, logic [19:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one block from handshake; returns when the DUT is back in IDLE or at stop_at.
    task automatic run_block(string nm, int ready_at, int flush_at, int pulse_at,
                             bit hold_iv, int stop_at);
        int c;
        bit fin;
        logic [19:0] e;
        in_valid  = 1'b1;
        flush     = (flush_at == 0);
        out_ready = (ready_at <= 0);
        #1;
        check({nm, "_hs_load"}, {19'd0, dp_load}, 20'd1);
        check({nm, "_c0"}, w_act, vec[0].e);
        flush = 1'b0;
        exp_q.delete();
        exp_q.push_back(vec[1].e);
        c   = 0;
        fin = 1'b0;
        while (!fin) begin
            tick();
            c++;
            if (c > 200) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s_timeout: got no return to idle expected within 200 cycles", nm);
                fin = 1'b1;
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s_c%0d_%s", nm, c, (c <= 22) ? vec[c].name : "DONE"), w_act, e);
                if (c == stop_at || e == idle_r) begin
                    fin = 1'b1;
                end else begin
                    in_valid  = hold_iv || (c == pulse_at);
                    flush     = (c == flush_at);
                    out_ready = (c >= ready_at);
                    #1;
                    check($sformatf("%s_c%0d_noload", nm, c), {19'd0, dp_load}, 20'd0);
                    if (flush)
                        exp_q.push_back(idle_r);
                    else if (c >= 22 && out_ready)
                        exp_q.push_back(idle_r);
                    else
                        exp_q.push_back(vec[(c + 1 <= 22) ? c + 1 : 22].e);
                end
            end
        end
        flush     = 1'b0;
        out_ready = 1'b1;
        if (!hold_iv) in_valid = 1'b0;
    endtask

    initial begin
        int nload;
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        rcon_tb = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                    8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        key_tab = '{128'h0000FFFF_0000FFFF_0000FFFF_0000FFFF,
                    128'h00FF00FF_00FF00FF_00FF00FF_00FF00FF,
                    128'hFF00FF00_FF00FF00_FF00FF00_FF00FF00};
        ct_word = '1;

        vec[0] = '{"IDLE", rec(1, 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'h00)};
        for (int k = 1; k <= 10; k++)
            vec[k] = '{"KEXP", rec(0, 1, 1, 0, 0, 0, 0, 0, 4'd0, rcon_tb[k-1])};
        vec[11] = '{"ARK", rec(0, 1, 0, 1, 1, 1, 0, 0, 4'd10, 8'h36)};
        for (int c = 12; c <= 20; c++)
            vec[c] = '{"ROUND", rec(0, 1, 0, 1, 1, 0, 0, 0, 4'(21 - c), rcon_tb[20 - c])};
        vec[21] = '{"FINAL", rec(0, 1, 0, 0, 1, 0, 1, 0, 4'd0, 8'h00)};
        vec[22] = '{"DONE", rec(0, 1, 0, 0, 0, 0, 0, 1, 4'd0, 8'h00)};
        idle_r  = vec[0].e;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("reset_state", w_act, idle_r);
        #2 rst_n = 1'b1;
        tick();
        check("idle_after_release", w_act, idle_r);

        // single block, key key_tab[0], ciphertext all-ones
        run_block("single", 0, -1, -1, 1'b0, -1);

        // consumer stalls in DONE for 5 cycles
        tick();
        run_block("stall", 27, -1, -1, 1'b0, -1);

        // flush during ROUND, then a normal block
        tick();
        run_block("flush_round", 0, 15, -1, 1'b0, -1);
        run_block("after_flush", 0, -1, -1, 1'b0, -1);

        // flush during a stalled DONE beats a later out_ready
        tick();
        run_block("flush_done", 100, 24, -1, 1'b0, -1);

        // flush in IDLE alongside the handshake
        tick();
        run_block("flush_idle", 0, 0, -1, 1'b0, -1);

        // in_valid pulse while busy
        tick();
        load_cyc.delete();
        run_block("busy_pulse", 0, -1, 5, 1'b0, -1);
        nload = load_cyc.size();
        check("busy_pulse_loads", 20'(nload), 20'd1);

        // three back-to-back blocks, in_valid held
        tick();
        load_cyc.delete();
        for (int b = 0; b < 3; b++)
            run_block($sformatf("b2b%0d", b), 0, -1, -1, 1'b1, -1);
        in_valid = 1'b0;
        tick();
        nload = load_cyc.size();
        check("b2b_loads", 20'(nload), 20'd3);
        if (nload == 3) begin
            check("b2b_gap1", 20'(load_cyc[1] - load_cyc[0]), 20'd23);
            check("b2b_gap2", 20'(load_cyc[2] - load_cyc[1]), 20'd23);
        end

        // reset in KEXP
        tick();
        run_block("pre_rst", 0, -1, -1, 1'b0, 7);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async", w_act, idle_r);
        tick();
        check("rst_held", w_act, idle_r);
        #3 rst_n = 1'b1;
        tick();
        check("rst_release", w_act, idle_r);
        run_block("post_rst", 0, -1, -1, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
